pulsador_acond: RTL and testbench

- Conditions the raw pedestrian pushbutton before it reaches the traffic-light controller.
- Synchronizes the asynchronous button and debounces it with a prescaled stability counter.
- Emits a 1-cycle press pulse and a latched pedestrian request level.
- The request holds until the controller clears it at the end of the pedestrian phase. The request output drives the controller's pushbutton input directly.

---
 rtl/pulsador_acond.sv | 168 ++++++++++++++++
 tb/tb_pulsador_acond.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pulsador_acond.sv
// ---------------------------------------------------------------------------
// pulsador_acond
//   Pedestrian pushbutton conditioner for the traffic-light controller.
//   The raw button is synchronized (2 FFs), then debounced by a 4-state FSM.
//   The FSM only advances its stability counter on prescaler ticks
//   (one tick every CLK_DIV clocks). A confirmed press produces a 1-cycle
//   strobe and sets a request level that the controller clears when the
//   pedestrian phase ends.
//
//   Optional build macro: BTN_ACTIVE_LOW_EN
//     defined   -> boton_in is active-low (pull-up wiring). It is inverted
//                  before the synchronizer, so s0/s1 always mean "pressed".
//     undefined -> boton_in is active-high.
//
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous, active-high reset
//     boton_in   in   raw asynchronous button
//     clr_req    in   1-cycle request clear from the controller
//     nivel      out  debounced button level
//     pulso      out  1-cycle strobe on each debounced press
//     solicitud  out  latched pedestrian request to the controller
// ---------------------------------------------------------------------------
module pulsador_acond #(
    parameter int CLK_DIV  = 50000,
    parameter int N_STABLE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic boton_in,
    input  logic clr_req,
    output logic nivel,
    output logic pulso,
    output logic solicitud
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int STB_W = $clog2(N_STABLE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(N_STABLE - 1);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);

    typedef enum logic [1:0] {
        EST0  = 2'd0,
        CONF1 = 2'd1,
        EST1  = 2'd2,
        CONF0 = 2'd3
    } state_t;

    state_t            state;
    logic              s0;
    logic              s1;
    logic              btn_sense;
    logic [DIV_W-1:0]  div_cnt;
    logic [STB_W-1:0]  stab_cnt;
    logic              tick;
    logic              last_tick;

`ifdef BTN_ACTIVE_LOW_EN
    assign btn_sense = ~boton_in;
`else
    assign btn_sense = boton_in;
`endif

    assign tick      = (div_cnt == DIV_LAST);
    // The tick that brings the count to N_STABLE completes the confirmation.
    assign last_tick = tick && (stab_cnt == STB_LAST);

    // Synchronizer and free-running prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            s0      <= 1'b0;
            s1      <= 1'b0;
            div_cnt <= '0;
        end else begin
            s0      <= btn_sense;
            s1      <= s0;
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Debounce FSM with registered outputs.
    // A tick that coincides with leaving a stable state already counts
    // toward the confirmation; this keeps the edge-to-level latency within
    // 2+(N_STABLE-1)*CLK_DIV+1 .. 2+N_STABLE*CLK_DIV clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EST0;
            stab_cnt  <= '0;
            nivel     <= 1'b0;
            pulso     <= 1'b0;
            solicitud <= 1'b0;
        end else begin
            pulso <= 1'b0;
            // Clear is ignored while pulso is high; a confirm below also
            // overrides it, so a press coinciding with a clear is kept.
            if (clr_req && !pulso) begin
                solicitud <= 1'b0;
            end

            case (state)
                EST0: begin
                    if (s1) begin
                        if (last_tick) begin
                            state     <= EST1;
                            nivel     <= 1'b1;
                            pulso     <= 1'b1;
                            solicitud <= 1'b1;
                            stab_cnt  <= '0;
                        end else begin
                            state    <= CONF1;
                            stab_cnt <= tick ? STB_ONE : '0;
                        end
                    end
                end

                CONF1: begin
                    if (!s1) begin
                        state    <= EST0;
                        stab_cnt <= '0;
                    end else if (last_tick) begin
                        state     <= EST1;
                        nivel     <= 1'b1;
                        pulso     <= 1'b1;
                        solicitud <= 1'b1;
                        stab_cnt  <= '0;
                    end else if (tick) begin
                        stab_cnt <= stab_cnt + STB_ONE;
                    end
                end

                EST1: begin
                    if (!s1) begin
                        if (last_tick) begin
                            state    <= EST0;
                            nivel    <= 1'b0;
                            stab_cnt <= '0;
                        end else begin
                            state    <= CONF0;
                            stab_cnt <= tick ? STB_ONE : '0;
                        end
                    end
                end

                CONF0: begin
                    if (s1) begin
                        state    <= EST1;
                        stab_cnt <= '0;
                    end else if (last_tick) begin
                        state    <= EST0;
                        nivel    <= 1'b0;
                        stab_cnt <= '0;
                    end else if (tick) begin
                        stab_cnt <= stab_cnt + STB_ONE;
                    end
                end

                default: begin
                    state    <= EST0;
                    stab_cnt <= '0;
                    nivel    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulsador_acond.sv
// ---------------------------------------------------------------------------
// tb_pulsador_acond
//   Self-checking bench for pulsador_acond with CLK_DIV=4, N_STABLE=3.
//   The reference model follows the debounce rule directly: while the
//   synchronized input differs from the debounced level, count prescaler
//   ticks. When the count reaches N_STABLE, flip the level. Press (and level)
//   values are handled in "pressed" sense; the physical pin polarity follows
//   BTN_ACTIVE_LOW_EN.
// ---------------------------------------------------------------------------
module tb_pulsador_acond;

    localparam int CLK_DIV  = 4;
    localparam int N_STABLE = 3;
    localparam int LAT_MIN  = 2 + (N_STABLE - 1) * CLK_DIV + 1;
    localparam int LAT_MAX  = 2 + N_STABLE * CLK_DIV;

`ifdef BTN_ACTIVE_LOW_EN
    localparam logic AL = 1'b1;
`else
    localparam logic AL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic boton_in;
    logic clr_req;
    logic nivel;
    logic pulso;
    logic solicitud;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic m_s0, m_s1, m_niv, m_pul, m_sol;
    int   m_div, m_run;

    pulsador_acond #(
        .CLK_DIV (CLK_DIV),
        .N_STABLE(N_STABLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .boton_in (boton_in),
        .clr_req  (clr_req),
        .nivel    (nivel),
        .pulso    (pulso),
        .solicitud(solicitud)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One clock: drive inputs, advance the model, sample after the edge.
    task automatic step(input logic press, input logic clr);
        logic tk;
        logic rise;
        int   cnt;
        boton_in = press ^ AL;
        clr_req  = clr;
        if (rst) begin
            m_s0 = 0; m_s1 = 0; m_niv = 0; m_pul = 0; m_sol = 0;
            m_div = 0; m_run = 0;
        end else begin
            tk   = (m_div == CLK_DIV - 1);
            rise = 1'b0;
            if (m_s1 != m_niv) begin
                cnt = m_run + int'(tk);
                if (cnt == N_STABLE) begin
                    rise  = !m_niv;
                    m_niv = !m_niv;
                    m_run = 0;
                end else begin
                    m_run = cnt;
                end
            end else begin
                m_run = 0;
            end
            m_sol = rise | m_pul | (m_sol & !clr);
            m_pul = rise;
            m_s1  = m_s0;
            m_s0  = press;
            m_div = tk ? 0 : m_div + 1;
        end
        @(posedge clk);
        #1;
        check_bit("nivel", nivel, m_niv);
        check_bit("pulso", pulso, m_pul);
        check_bit("solicitud", solicitud, m_sol);
    endtask

    task automatic hold(input logic press, input int n);
        for (int i = 0; i < n; i++) step(press, 1'b0);
    endtask

    // Hold press until nivel rises; returns steps taken and pulses seen.
    task automatic press_measure(output int lat, output int npul);
        lat  = -1;
        npul = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0);
            if (pulso === 1'b1) npul++;
            if (nivel === 1'b1 && lat < 0) lat = i;
        end
    endtask

    initial begin
        int lat, npul;
        logic pr;

        // 1. reset held with button pressed
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            check_bit("rst_nivel", nivel, 1'b0);
            check_bit("rst_pulso", pulso, 1'b0);
            check_bit("rst_sol", solicitud, 1'b0);
        end
        rst = 1'b0;
        press_measure(lat, npul);
        check_range("post_rst_latency", lat, LAT_MIN, LAT_MAX);
        check_range("post_rst_pulses", npul, 1, 1);
        hold(1'b0, 20);
        step(1'b0, 1'b1);
        check_bit("clr_after_rst", solicitud, 1'b0);

        // 2. clean press from idle
        press_measure(lat, npul);
        check_range("clean_latency", lat, LAT_MIN, LAT_MAX);
        check_range("clean_pulses", npul, 1, 1);
        check_bit("clean_sol_hold", solicitud, 1'b1);
        hold(1'b0, 20);

        // 3. bounce: 5 high, 2 low, then held
        step(1'b0, 1'b1);
        hold(1'b1, 5);
        hold(1'b0, 2);
        press_measure(lat, npul);
        check_range("bounce_latency", lat, LAT_MIN, LAT_MAX);
        check_range("bounce_pulses", npul, 1, 1);
        hold(1'b0, 20);

        // 4. glitch 6 high -> nothing
        step(1'b0, 1'b1);
        hold(1'b1, 6);
        hold(1'b0, 20);
        check_bit("glitch_nivel", nivel, 1'b0);
        check_bit("glitch_sol", solicitud, 1'b0);

        // 5. clear alone, then clear coinciding with pulso
        press_measure(lat, npul);
        hold(1'b0, 20);
        step(1'b0, 1'b1);
        check_bit("clr_alone", solicitud, 1'b0);
        for (int i = 0; i < 40 && !m_pul; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_bit("set_wins", solicitud, 1'b1);
        hold(1'b0, 20);

        // reset mid-debounce aborts and restarts confirmation
        hold(1'b1, 8);
        rst = 1'b1;
        hold(1'b1, 2);
        rst = 1'b0;
        press_measure(lat, npul);
        check_range("mid_rst_latency", lat, LAT_MIN, LAT_MAX);
        hold(1'b0, 20);

        // randomized runs against the model
        pr = 1'b0;
        for (int r = 0; r < 60; r++) begin
            int len;
            pr  = ~pr;
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++)
                step(pr, ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
